// File: rtl/csr_unit_v2_pkg.sv
// ============================================================================
// Module   : csr_unit_v2_pkg
// Brief    : Shared constants, encodings and helpers for the M-mode CSR unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csr_unit_v2_pkg;

  localparam logic [11:0] c_addr_mstatus  = 12'h300;
  localparam logic [11:0] c_addr_misa     = 12'h301;
  localparam logic [11:0] c_addr_mie      = 12'h304;
  localparam logic [11:0] c_addr_mtvec    = 12'h305;
  localparam logic [11:0] c_addr_mscratch = 12'h340;
  localparam logic [11:0] c_addr_mepc     = 12'h341;
  localparam logic [11:0] c_addr_mcause   = 12'h342;
  localparam logic [11:0] c_addr_mtval    = 12'h343;
  localparam logic [11:0] c_addr_mip      = 12'h344;
  localparam logic [11:0] c_addr_mcycle   = 12'hB00;
  localparam logic [11:0] c_addr_mcycleh  = 12'hB80;
  localparam logic [11:0] c_addr_minstret = 12'hB02;
  localparam logic [11:0] c_addr_minstreth = 12'hB82;

  localparam int c_mstatus_mie  = 3;
  localparam int c_mstatus_mpie = 7;
  localparam int c_mip_mtip     = 7;
  localparam int c_mip_meip     = 11;

  localparam logic [31:0] c_misa_val    = 32'h4000_0100;
  localparam logic [31:0] c_mie_mask    = 32'h0000_0880;
  localparam logic [31:0] c_cause_mtime = 32'h8000_0007;
  localparam logic [31:0] c_cause_mext  = 32'h8000_000B;

  typedef enum logic [1:0] {
    WSC_WRITE0 = 2'b00,
    WSC_WRITE  = 2'b01,
    WSC_SET    = 2'b10,
    WSC_CLEAR  = 2'b11
  } wsc_mode_e;

  function automatic logic [31:0] f_apply_wsc(input logic [1:0]  mode,
                                              input logic [31:0] old,
                                              input logic [31:0] operand);
    case (wsc_mode_e'(mode))
      WSC_SET:   return old | operand;
      WSC_CLEAR: return old & ~operand;
      default:   return operand;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_unit_v2_if.sv
// ============================================================================
// Module   : csr_unit_v2_if
// Brief    : CSR access port (combinational read, single write) between core and CSR unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_unit_v2_if #(
  parameter int XLEN = 32
);
  logic [11:0]     raddr;
  logic [XLEN-1:0] rdata;
  logic            r_illegal;
  logic [11:0]     waddr;
  logic [XLEN-1:0] wdata;
  logic            csr_w;
  logic [1:0]      csr_wsc_mode;

  modport master (
    output raddr, waddr, wdata, csr_w, csr_wsc_mode,
    input  rdata, r_illegal
  );

  modport slave (
    input  raddr, waddr, wdata, csr_w, csr_wsc_mode,
    output rdata, r_illegal
  );
endinterface

`default_nettype wire

// File: rtl/csr_unit_v2_counter64.sv
// ============================================================================
// Module   : csr_counter64
// Brief    : 64-bit free-running counter with independently writable halves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_counter64 (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        inc_i,
  input  wire logic        wr_lo_i,
  input  wire logic        wr_hi_i,
  input  wire logic [31:0] wdata_i,
  output logic      [63:0] value_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // A write to either half suppresses that cycle's increment for all 64 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/csr_unit_v2.sv
// ============================================================================
// Module   : csr_unit_v2
// Brief    : Machine-mode CSR file with WARL masking, counters, interrupts and trap vectoring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_unit_v2
  import csr_unit_v2_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              COUNTERS_EN = 1,
  parameter int              VECTORED_EN = 1,
  parameter logic [XLEN-1:0] MTVEC_RST   = 32'h0000_0000
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  csr_unit_v2_if.slave         bus,
  input  wire logic            trap_i,
  input  wire logic [XLEN-1:0] trap_cause_i,
  input  wire logic [XLEN-1:0] trap_pc_i,
  input  wire logic [XLEN-1:0] trap_val_i,
  input  wire logic            mret_i,
  input  wire logic            instret_i,
  input  wire logic            timer_irq_i,
  input  wire logic            ext_irq_i,
  output logic                 irq_req_o,
  output logic      [XLEN-1:0] irq_cause_o,
  output logic      [XLEN-1:0] trap_vector_o,
  output logic      [XLEN-1:0] mepc_out_o,
  output logic      [XLEN-1:0] mstatus_o
);

  logic            mie_bit_q, mpie_q;
  logic [XLEN-1:0] mie_q, mip_q, mip_d;
  logic [XLEN-3:0] mtvec_base_q;
  logic [1:0]      mtvec_mode_q;
  logic [XLEN-1:0] mscratch_q, mepc_q, mcause_q, mtval_q;

  logic [XLEN-1:0]   w_mstatus, w_mtvec, w_old, w_wval, w_pend, w_tvec_base;
  logic [XLEN:0]     w_rd_r, w_rd_w;
  logic [2*XLEN-1:0] w_mcycle, w_minstret;
  logic              w_wen;

  always_comb begin
    w_mstatus                 = '0;
    w_mstatus[12:11]          = 2'b11;
    w_mstatus[c_mstatus_mpie] = mpie_q;
    w_mstatus[c_mstatus_mie]  = mie_bit_q;
  end

  assign w_mtvec = {mtvec_base_q, (VECTORED_EN != 0) ? mtvec_mode_q : 2'b00};

  // Returns {illegal, data}; shared by the read port and the set/clear path.
  function automatic logic [XLEN:0] f_read(input logic [11:0] addr);
    case (addr)
      c_addr_mstatus:   return {1'b0, w_mstatus};
      c_addr_misa:      return {1'b0, c_misa_val};
      c_addr_mie:       return {1'b0, mie_q};
      c_addr_mtvec:     return {1'b0, w_mtvec};
      c_addr_mscratch:  return {1'b0, mscratch_q};
      c_addr_mepc:      return {1'b0, mepc_q};
      c_addr_mcause:    return {1'b0, mcause_q};
      c_addr_mtval:     return {1'b0, mtval_q};
      c_addr_mip:       return {1'b0, mip_q};
      c_addr_mcycle:    return {1'b0, w_mcycle[XLEN-1:0]};
      c_addr_mcycleh:   return {1'b0, w_mcycle[2*XLEN-1:XLEN]};
      c_addr_minstret:  return {1'b0, w_minstret[XLEN-1:0]};
      c_addr_minstreth: return {1'b0, w_minstret[2*XLEN-1:XLEN]};
      default:          return {1'b1, {XLEN{1'b0}}};
    endcase
  endfunction

  assign w_rd_r        = f_read(bus.raddr);
  assign w_rd_w        = f_read(bus.waddr);
  assign bus.r_illegal = w_rd_r[XLEN];
  assign bus.rdata     = w_rd_r[XLEN-1:0];
  assign w_old         = w_rd_w[XLEN-1:0];
  assign w_wval        = f_apply_wsc(bus.csr_wsc_mode, w_old, bus.wdata);

  // Trap and mret flush any CSR instruction sharing their cycle.
  assign w_wen = bus.csr_w & ~trap_i & ~mret_i;

  always_comb begin
    mip_d             = '0;
    mip_d[c_mip_mtip] = timer_irq_i;
    mip_d[c_mip_meip] = ext_irq_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_bit_q    <= 1'b0;
      mpie_q       <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mtvec_base_q <= MTVEC_RST[XLEN-1:2];
      mtvec_mode_q <= MTVEC_RST[1:0];
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      mip_q <= mip_d;
      if (trap_i) begin
        mepc_q    <= {trap_pc_i[XLEN-1:2], 2'b00};
        mcause_q  <= trap_cause_i;
        mtval_q   <= trap_val_i;
        mpie_q    <= mie_bit_q;
        mie_bit_q <= 1'b0;
      end else if (mret_i) begin
        mie_bit_q <= mpie_q;
        mpie_q    <= 1'b1;
      end else if (w_wen) begin
        case (bus.waddr)
          c_addr_mstatus: begin
            mie_bit_q <= w_wval[c_mstatus_mie];
            mpie_q    <= w_wval[c_mstatus_mpie];
          end
          c_addr_mie:      mie_q      <= w_wval & c_mie_mask;
          c_addr_mscratch: mscratch_q <= w_wval;
          c_addr_mepc:     mepc_q     <= {w_wval[XLEN-1:2], 2'b00};
          c_addr_mcause:   mcause_q   <= w_wval;
          c_addr_mtval:    mtval_q    <= w_wval;
          c_addr_mtvec: begin
            mtvec_base_q <= w_wval[XLEN-1:2];
            // Reserved modes 2/3 leave the previous mode in place.
            if ((VECTORED_EN != 0) && !w_wval[1]) begin
              mtvec_mode_q <= w_wval[1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  generate
    if (COUNTERS_EN != 0) begin : g_counters
      csr_counter64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .wr_lo_i (w_wen && (bus.waddr == c_addr_mcycle)),
        .wr_hi_i (w_wen && (bus.waddr == c_addr_mcycleh)),
        .wdata_i (w_wval),
        .value_o (w_mcycle)
      );
      csr_counter64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (instret_i),
        .wr_lo_i (w_wen && (bus.waddr == c_addr_minstret)),
        .wr_hi_i (w_wen && (bus.waddr == c_addr_minstreth)),
        .wdata_i (w_wval),
        .value_o (w_minstret)
      );
    end else begin : g_no_counters
      assign w_mcycle   = '0;
      assign w_minstret = '0;
    end
  endgenerate

  assign w_pend    = mip_q & mie_q;
  assign irq_req_o = mie_bit_q & |w_pend;

  always_comb begin
    irq_cause_o = '0;
    if (w_pend[c_mip_meip]) begin
      irq_cause_o = c_cause_mext;
    end else if (w_pend[c_mip_mtip]) begin
      irq_cause_o = c_cause_mtime;
    end
  end

  assign w_tvec_base = {mtvec_base_q, 2'b00};

  always_comb begin
    trap_vector_o = w_tvec_base;
    if ((w_mtvec[1:0] == 2'b01) && trap_cause_i[XLEN-1]) begin
      trap_vector_o = w_tvec_base + {{(XLEN-7){1'b0}}, trap_cause_i[4:0], 2'b00};
    end
  end

  assign mepc_out_o = mepc_q;
  assign mstatus_o  = w_mstatus;

endmodule

`default_nettype wire

// File: tb/tb_csr_unit_v2.sv
// ============================================================================
// Module   : tb_csr_unit_v2
// Brief    : Directed self-checking bench for csr_unit_v2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_unit_v2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap, mret, instret, timer_irq, ext_irq;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        irq_req;
  logic [31:0] irq_cause, trap_vector, mepc_out, mstatus;
  int          checks = 0;
  int          errors = 0;

  csr_unit_v2_if #(.XLEN(32)) bus ();

  csr_unit_v2 #(
    .XLEN(32), .COUNTERS_EN(1), .VECTORED_EN(1), .MTVEC_RST(32'h0000_0100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .trap_i(trap), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .trap_val_i(trap_val),
    .mret_i(mret), .instret_i(instret), .timer_irq_i(timer_irq), .ext_irq_i(ext_irq),
    .irq_req_o(irq_req), .irq_cause_o(irq_cause), .trap_vector_o(trap_vector),
    .mepc_out_o(mepc_out), .mstatus_o(mstatus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    bus.raddr = a;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] m);
    bus.waddr = a; bus.wdata = d; bus.csr_wsc_mode = m; bus.csr_w = 1'b1;
    tick();
    bus.csr_w = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trap = 0; mret = 0; instret = 0; timer_irq = 0; ext_irq = 0;
    trap_cause = '0; trap_pc = '0; trap_val = '0;
    bus.raddr = '0; bus.waddr = '0; bus.wdata = '0; bus.csr_w = 0; bus.csr_wsc_mode = 2'b01;
    #23; rst_n = 1'b1; tick();
    rd(12'h300);
    checks++; if (bus.rdata !== 32'h1800 || bus.r_illegal !== 1'b0) begin errors++; $display("FAIL rst_mstatus got %h/%b exp 00001800/0", bus.rdata, bus.r_illegal); end
    rd(12'h305);
    checks++; if (bus.rdata !== 32'h100) begin errors++; $display("FAIL rst_mtvec got %h exp 00000100", bus.rdata); end
    rd(12'h301);
    checks++; if (bus.rdata !== 32'h4000_0100) begin errors++; $display("FAIL rst_misa got %h exp 40000100", bus.rdata); end
    rd(12'h304);
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_mie got %h exp 0", bus.rdata); end
    rd(12'h7C0);
    checks++; if (bus.r_illegal !== 1'b1 || bus.rdata !== 32'h0) begin errors++; $display("FAIL illegal_addr got %h/%b exp 00000000/1", bus.rdata, bus.r_illegal); end
    checks++; if (irq_req !== 1'b0 || trap_vector !== 32'h100 || mstatus !== 32'h1800) begin errors++; $display("FAIL rst_outs got irq=%b tv=%h ms=%h exp 0/00000100/00001800", irq_req, trap_vector, mstatus); end
  endtask

  task automatic test_warl();
    wr(12'h305, 32'h200, 2'b01);
    wr(12'h305, 32'h203, 2'b01);
    rd(12'h305);
    checks++; if (bus.rdata !== 32'h200) begin errors++; $display("FAIL mtvec_mode_keep got %h exp 00000200", bus.rdata); end
    wr(12'h341, 32'h107, 2'b01);
    rd(12'h341);
    checks++; if (bus.rdata !== 32'h104) begin errors++; $display("FAIL mepc_align got %h exp 00000104", bus.rdata); end
    wr(12'h300, 32'hFFFF_FFFF, 2'b01);
    rd(12'h300);
    checks++; if (bus.rdata !== 32'h1888) begin errors++; $display("FAIL mstatus_warl got %h exp 00001888", bus.rdata); end
    wr(12'h300, 32'h0, 2'b00);
    wr(12'h301, 32'h0, 2'b01);
    rd(12'h301);
    checks++; if (bus.rdata !== 32'h4000_0100) begin errors++; $display("FAIL misa_ro got %h exp 40000100", bus.rdata); end
    wr(12'h340, 32'h55, 2'b01);
    bus.waddr = 12'h340; bus.wdata = 32'hAA; bus.csr_wsc_mode = 2'b01; bus.csr_w = 1'b1;
    rd(12'h340);
    checks++; if (bus.rdata !== 32'h55) begin errors++; $display("FAIL rd_during_wr got %h exp 00000055", bus.rdata); end
    tick(); bus.csr_w = 1'b0;
    wr(12'h340, 32'h0F, 2'b10);
    rd(12'h340);
    checks++; if (bus.rdata !== 32'hAF) begin errors++; $display("FAIL wsc_set got %h exp 000000AF", bus.rdata); end
    wr(12'h340, 32'hA0, 2'b11);
    rd(12'h340);
    checks++; if (bus.rdata !== 32'h0F) begin errors++; $display("FAIL wsc_clear got %h exp 0000000F", bus.rdata); end
  endtask

  task automatic test_irq();
    wr(12'h304, 32'h888, 2'b01);
    rd(12'h304);
    checks++; if (bus.rdata !== 32'h880) begin errors++; $display("FAIL mie_warl got %h exp 00000880", bus.rdata); end
    wr(12'h300, 32'h8, 2'b10);
    checks++; if (mstatus !== 32'h1808) begin errors++; $display("FAIL mstatus_set got %h exp 00001808", mstatus); end
    timer_irq = 1'b1; #1;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", irq_req); end
    tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_0007) begin errors++; $display("FAIL irq_timer got %b/%h exp 1/80000007", irq_req, irq_cause); end
    rd(12'h344);
    checks++; if (bus.rdata !== 32'h80) begin errors++; $display("FAIL mip_rd got %h exp 00000080", bus.rdata); end
    ext_irq = 1'b1; tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_cause !== 32'h8000_000B) begin errors++; $display("FAIL irq_ext_prio got %b/%h exp 1/8000000B", irq_req, irq_cause); end
    timer_irq = 1'b0; ext_irq = 1'b0; tick(); tick();
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq_req); end
  endtask

  task automatic test_trap();
    wr(12'h305, 32'h1001, 2'b01);
    trap_cause = 32'h8000_0007; trap_pc = 32'h204; trap_val = 32'h33; #1;
    checks++; if (trap_vector !== 32'h101C) begin errors++; $display("FAIL tvec_vectored got %h exp 0000101C", trap_vector); end
    trap = 1'b1;
    bus.waddr = 12'h340; bus.wdata = 32'hDEAD; bus.csr_wsc_mode = 2'b01; bus.csr_w = 1'b1;
    tick(); trap = 1'b0; bus.csr_w = 1'b0;
    checks++; if (mepc_out !== 32'h204 || mstatus !== 32'h1880) begin errors++; $display("FAIL trap_state got mepc=%h ms=%h exp 00000204/00001880", mepc_out, mstatus); end
    rd(12'h342);
    checks++; if (bus.rdata !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause got %h exp 80000007", bus.rdata); end
    rd(12'h343);
    checks++; if (bus.rdata !== 32'h33) begin errors++; $display("FAIL trap_mtval got %h exp 00000033", bus.rdata); end
    rd(12'h340);
    checks++; if (bus.rdata !== 32'h0F) begin errors++; $display("FAIL trap_drops_wr got %h exp 0000000F", bus.rdata); end
    trap_cause = 32'h0000_0002; #1;
    checks++; if (trap_vector !== 32'h1000) begin errors++; $display("FAIL tvec_exception got %h exp 00001000", trap_vector); end
    mret = 1'b1;
    bus.waddr = 12'h340; bus.wdata = 32'hBEEF; bus.csr_wsc_mode = 2'b01; bus.csr_w = 1'b1;
    tick(); mret = 1'b0; bus.csr_w = 1'b0;
    rd(12'h340);
    checks++; if (mstatus !== 32'h1888 || mepc_out !== 32'h204 || bus.rdata !== 32'h0F) begin errors++; $display("FAIL mret_state got ms=%h mepc=%h scr=%h exp 00001888/00000204/0000000F", mstatus, mepc_out, bus.rdata); end
  endtask

  task automatic test_counters();
    wr(12'hB00, 32'hFFFF_FFFE, 2'b01);
    wr(12'hB80, 32'h5, 2'b01);
    rd(12'hB00);
    checks++; if (bus.rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cyc_wr_hold got %h exp FFFFFFFE", bus.rdata); end
    tick(); tick();
    rd(12'hB80);
    checks++; if (bus.rdata !== 32'h6) begin errors++; $display("FAIL cyc_carry_hi got %h exp 00000006", bus.rdata); end
    rd(12'hB00);
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL cyc_wrap_lo got %h exp 00000000", bus.rdata); end
    wr(12'hB02, 32'd10, 2'b01);
    instret = 1'b1; tick(); tick(); tick();
    instret = 1'b0; tick();
    rd(12'hB02);
    checks++; if (bus.rdata !== 32'd13) begin errors++; $display("FAIL instret_cnt got %0d exp 13", bus.rdata); end
    rd(12'hB82);
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL instret_hi got %h exp 00000000", bus.rdata); end
  endtask

  initial begin
    test_reset();
    test_warl();
    test_irq();
    test_trap();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/csr_unit_v2.md
Name: csr_unit_v2

Overview:
Parametrised machine-mode CSR unit for the pipelined RV32 core; successor to the flat 16-entry CSR array. Adds real RISC-V addresses, WARL field masking, 64-bit mcycle/minstret counters, mip/mie interrupt-pending logic and vectored mtvec. Sits beside the ID/EX stage: combinational read port, one write port, trap entry/exit from the exception unit.

Parameters:
XLEN, 32, data width of all CSRs (32 only for now; counters split lo/hi).
COUNTERS_EN, 1, 1 = implement mcycle/minstret (+h); 0 = reads return 0, address still legal.
VECTORED_EN, 1, 1 = honour mtvec.MODE=1; 0 = MODE field reads 0 and is not writable.
MTVEC_RST, 32'h0000_0000, reset value of mtvec.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous reset, active-low
raddr  in  12  CSR read address
rdata  out  XLEN  read data, combinational
r_illegal  out  1  raddr not implemented
waddr  in  12  CSR write address
wdata  in  XLEN  write operand
csr_w  in  1  write enable
csr_wsc_mode  in  2  01 write, 10 set, 11 clear, 00 write
trap  in  1  take trap this cycle
trap_cause  in  XLEN  mcause value (bit31 = interrupt)
trap_pc  in  XLEN  faulting/interrupted PC
trap_val  in  XLEN  mtval value
mret  in  1  return from trap this cycle
instret  in  1  one instruction retired
timer_irq  in  1  machine timer interrupt level
ext_irq  in  1  machine external interrupt level
irq_req  out  1  enabled interrupt pending
irq_cause  out  XLEN  cause for irq_req (0x8000_000B ext, 0x8000_0007 timer)
trap_vector  out  XLEN  PC to fetch on trap
mepc_out  out  XLEN  mepc for mret
mstatus  out  XLEN  current mstatus

Behaviour:
- Map: 0x300 mstatus, 0x301 misa (RO 0x4000_0100), 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip (RO), 0xB00/0xB80 mcycle/h, 0xB02/0xB82 minstret/h. Anything else: r_illegal=1, rdata=0; writes ignored.
- Reset (rst_n low, async): mstatus=0x0000_1800 (MPP=11), mie=0, mtvec=MTVEC_RST, others 0, counters 0. Outputs follow: irq_req=0, trap_vector=MTVEC_RST&~3.
- WARL: mstatus writable bits MIE[3], MPIE[7] only; MPP reads 11. mie writable bits 7,11. mepc[1:0] forced 0. mtvec MODE 2/3 write keeps old MODE, base still updated. Writes to misa/mip dropped.
- Writes take effect next edge; read of same address in write cycle returns old value.
- Priority per cycle: trap > mret > csr_w. Lower-priority request that same cycle is dropped entirely (pipeline flushes it).
- trap: mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_val, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1. mepc/mcause/mtval unchanged.
- mip: MTIP(7)/MEIP(11) registered from inputs each cycle (1-cycle latency).
- irq_req = mstatus.MIE & |(mip & mie), combinational on registers. Ext has priority over timer for irq_cause.
- trap_vector: base=mtvec&~3; if MODE=1, VECTORED_EN and trap_cause[31], base+4*trap_cause[4:0]; else base. Combinational on trap_cause.
- mcycle += 1 every cycle; minstret += instret. 64-bit, wraps 2^64-1 -> 0. CSR write to a counter half wins over that cycle's increment for the whole 64-bit counter (other half keeps old value); carry from lo to hi in the same cycle when lo=0xFFFF_FFFF.
- Counter writes allowed while trap/mret not active; trap/mret never stall counters.

Decomposition:
- Shared package/header: CSR address constants, mstatus bit indices, mcause interrupt codes, misa constant, wsc mode encodings.
- One sub-module: csr_counter64 (lo/hi write ports, increment enable, carry) instantiated twice.

Test Plan:
- Reset, read 0x300/0x305/0x301 -> 0x1800/MTVEC_RST/0x4000_0100; read 0x7C0 -> r_illegal=1, rdata=0.
- Write mie=0x888 then set mstatus 0x8, assert timer_irq -> 2 cycles later irq_req=1, irq_cause=0x8000_0007; add ext_irq -> cause 0x8000_000B.
- mtvec=0x1001, trap with cause 0x8000_0007 pc 0x204 -> trap_vector=0x101C, mepc=0x204, MIE=0, MPIE=1; mret -> MIE=1.
- trap and csr_w to mscratch same cycle -> mscratch unchanged, trap state updated.
- Write mcycle=0xFFFF_FFFE, mcycleh=5 -> two cycles on, mcycleh=6, mcycle wrapped to 0.
- Write mtvec=0x203 -> reads 0x200 (old MODE 0 kept); mepc write 0x107 -> reads 0x104.
